// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared across the MIPS pipeline stages.
//   INSTR_W       - instruction word width
//   NOP_WORD      - encoding used for pipeline bubbles
//   fetch_state_t - fetch stage state, also seen by the hazard unit and debug
//   pc_word_index - byte PC to instruction-memory word index
package mips_pkg;

  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h8000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  function automatic logic [31:0] pc_word_index(input logic [31:0] byte_pc);
    return {2'b00, byte_pc[31:2]};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: pipeline register carrying an instruction, its next PC and a
// valid flag. It is written generically so it can also serve as an
// ID/EX-style register.
//
// Ports:
//   clk     in   pipeline clock
//   rst     in   synchronous active-high reset, loads a bubble with npc = 0
//   squash  in   load a bubble (instr = NOP, valid = 0), wins over hold
//   hold    in   keep the current contents
//   instr_d in   instruction to capture
//   npc_d   in   next PC to capture
//   valid_d in   valid flag to capture
//   instr   out  registered instruction
//   npc     out  registered next PC
//   valid   out  registered valid flag
module if_id_reg
  import mips_pkg::*;
#(
  parameter int                 W   = INSTR_W,
  parameter logic [W-1:0]       NOP = W'(mips_pkg::NOP_WORD)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         squash,
  input  logic         hold,
  input  logic [W-1:0] instr_d,
  input  logic [31:0]  npc_d,
  input  logic         valid_d,
  output logic [W-1:0] instr,
  output logic [31:0]  npc,
  output logic         valid
);

  // A squashed bubble keeps the previous npc; only the instruction and the
  // valid flag define a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr <= NOP;
      npc   <= 32'h0;
      valid <= 1'b0;
    end else if (squash) begin
      instr <= NOP;
      valid <= 1'b0;
    end else if (!hold) begin
      instr <= instr_d;
      npc   <= npc_d;
      valid <= valid_d;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction-fetch stage. Owns the PC, addresses the
// combinational instruction memory and registers the returned word into the
// IF/ID register. Supports stall, redirect with squash, and a sticky halt on
// an out-of-range fetch.
//
//   state | meaning
//   RUN   | fetching; advance, stall or trap on an out-of-range PC
//   HALT  | out-of-range fetch seen; PC frozen, bubbles issued every cycle
//
// Ports:
//   clk            in   pipeline clock
//   rst            in   synchronous active-high reset
//   stall          in   hazard hold of PC and IF/ID
//   redirect_valid in   branch/jump taken this cycle
//   redirect_pc    in   byte target, bits [1:0] ignored
//   imem_addr      out  word index {2'b00, pc[31:2]}
//   imem_data      in   instruction word at imem_addr
//   if_id_instr    out  registered instruction
//   if_id_npc      out  registered PC+4 of that instruction
//   if_id_valid    out  1 = real instruction, 0 = bubble
//   pc             out  current fetch PC (byte address)
//   halted         out  sticky out-of-range fault
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 129,
  parameter logic [31:0] NOP_WORD   = mips_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_npc,
  output logic        if_id_valid,
  output logic [31:0] pc,
  output logic        halted
);

  localparam logic [31:0] DEPTH_W    = 32'(IMEM_DEPTH);
  localparam logic [31:0] PC_RESET_A = RESET_PC & ~32'h3;

  fetch_state_t state, state_next;

  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic        in_range;
  logic        ifid_squash;
  logic        ifid_hold;

  logic        unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc_word_index(pc);
  assign in_range  = (imem_addr < DEPTH_W);
  assign halted    = (state == HALT);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state: redirect always returns to RUN, an unstalled out-of-range
  // fetch traps into HALT, and HALT is otherwise absorbing.
  always_comb begin
    state_next = state;
    if (redirect_valid) begin
      state_next = RUN;
    end else begin
      case (state)
        RUN:     if (!stall && !in_range) state_next = HALT;
        HALT:    state_next = HALT;
        default: state_next = RUN;
      endcase
    end
  end

  // Outputs: next PC and IF/ID control.
  // Priority: redirect > HALT > stall > out-of-range trap > advance.
  always_comb begin
    pc_next     = pc;
    ifid_squash = 1'b0;
    ifid_hold   = 1'b0;
    if (redirect_valid) begin
      pc_next     = {redirect_pc[31:2], 2'b00};
      ifid_squash = 1'b1;
    end else if (state == HALT) begin
      ifid_squash = 1'b1;
    end else if (stall) begin
      ifid_hold   = 1'b1;
    end else if (!in_range) begin
      ifid_squash = 1'b1;
    end else begin
      pc_next     = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= PC_RESET_A;
    end else begin
      pc <= pc_next;
    end
  end

  if_id_reg #(
    .W   (32),
    .NOP (NOP_WORD)
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .squash  (ifid_squash),
    .hold    (ifid_hold),
    .instr_d (imem_data),
    .npc_d   (pc_plus4),
    .valid_d (1'b1),
    .instr   (if_id_instr),
    .npc     (if_id_npc),
    .valid   (if_id_valid)
  );

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch (IF) stage for the MIPS pipeline. It is the initiator and reader for the instruction memory: it owns the program counter, drives the word address into the combinational instruction memory, and registers the returned word into the IF/ID pipeline register. It supports stall, branch/jump redirect with squash, and a sticky halt on out-of-range fetch.

## Interface
- RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset.
- IMEM_DEPTH, 129, number of 32-bit words in instruction memory; valid word indices are 0..IMEM_DEPTH-1.
- NOP_WORD, 32'h8000_0000, pipeline NOP encoding used for bubbles.

- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit hold; freezes the PC and IF/ID.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  byte-address target; bits [1:0] are ignored (forced to 0).
- imem_addr  out  32  word index to instruction memory, equal to {2'b00, pc[31:2]}; combinational from the PC.
- imem_data  in  32  instruction word, combinational from imem_addr.
- if_id_instr  out  32  registered instruction.
- if_id_npc  out  32  registered PC+4 of that instruction.
- if_id_valid  out  1  1 = real instruction, 0 = bubble (if_id_instr = NOP_WORD).
- pc  out  32  current fetch PC (byte address).
- halted  out  1  sticky out-of-range fault.

## Operation
- States: RUN and HALT. Reset enters RUN.
- Reset values: pc = RESET_PC & ~3; if_id_instr = NOP_WORD; if_id_npc = 0; if_id_valid = 0; halted = 0.
- Per-edge priority: rst > redirect_valid > HALT > stall > advance.
- Advance (RUN, no stall, no redirect, in range): if_id_instr ← imem_data; if_id_npc ← pc+4; if_id_valid ← 1; pc ← pc+4. PC arithmetic is 32-bit modulo, so 32'hFFFF_FFFC + 4 = 0.
- Range check: the fetch is in range when pc[31:2] < IMEM_DEPTH.
- Out-of-range fetch in RUN without stall or redirect:
  - IF/ID ← bubble (NOP_WORD, valid 0).
  - pc holds.
  - Go to HALT, set halted = 1.
- Stall (RUN, no redirect): pc, if_id_instr, if_id_npc and if_id_valid all hold.
- Redirect, in any state and regardless of stall:
  - pc ← {redirect_pc[31:2], 2'b00}.
  - IF/ID ← bubble, squashing the wrong-path word.
  - State ← RUN, halted ← 0.
- HALT: pc holds; IF/ID is loaded with a bubble every cycle; stall has no effect. Exit only via redirect or rst.
- imem_addr always reflects the current pc, including while stalled or halted.

## Timing
- Fetch latency: 1 cycle. The word at pc appears on if_id_instr after the next rising edge.
- Redirect penalty: 1 bubble. The target instruction appears 2 edges after redirect_valid is sampled.
- Stall is sampled at the edge. A 1-cycle stall repeats exactly one IF/ID value for one extra cycle.
- Reset mid-stream: a single rst edge discards IF/ID contents. The first valid instruction appears on the edge after rst deasserts.
- stall and redirect_valid asserted together: redirect wins, with no hold.

## Structure
- Shared package mips_pkg holds:
  - NOP_WORD constant.
  - Instruction word width (32).
  - fetch_state_t enum {RUN, HALT}, also used by the hazard unit and debug.
- Sub-module: if_id_reg, the IF/ID pipeline register with hold and squash inputs. It is reused later for ID/EX-style registers.
- The PC and next-PC mux live in instr_fetch.
- The bench instantiates instruction memory with known contents and connects it to imem_addr/imem_data.

## Test plan
- Reset then free-run, memory word i = 32'h1000_0000+i: after rst, successive edges give if_id_instr = 1000_0000, 1000_0001, 1000_0002 with if_id_npc = 4, 8, 12 and valid = 1.
- Stall 3 cycles at pc = 8: pc stays 8, if_id_instr stays 1000_0001 for 3 extra cycles, then resumes with 1000_0002.
- Redirect to 32'h0000_0043 while stalled: next edge gives pc = 0x40, if_id_valid = 0, if_id_instr = 8000_0000; the following edge gives if_id_instr = 1000_0010.
- Run off the end with IMEM_DEPTH = 4: at pc = 16, halted = 1 and bubbles repeat with pc stuck at 16. Redirect to 0 then clears halted and fetch restarts at word 0.
- Reset asserted mid-run at pc = 0x20: the next edge gives pc = RESET_PC, if_id_valid = 0, halted = 0.
- Simultaneous rst and redirect_valid: reset wins, pc = RESET_PC.
